// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the shared RAM port. Serialises accesses and supports locked bursts.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise requester A has fixed priority.
module ram_port_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    owner
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StServeA = 3'd1,
        StServeB = 3'd2,
        StLockA  = 3'd3,
        StLockB  = 3'd4
    } state_e;

    state_e          state_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            a_ack_q;
    logic            b_ack_q;
    logic [DW-1:0]   a_rdata_q;
    logic [DW-1:0]   b_rdata_q;

    logic            a_elig;
    logic            b_elig;
    logic            a_wins;
    logic            accept_a;
    logic            accept_b;

    // A requester whose ack is high this cycle is masked so it cannot be re-served immediately.
    assign a_elig = a_req & ~a_ack_q;
    assign b_elig = b_req & ~b_ack_q;

`ifdef RAM_ARB_RR_EN
    logic b_last_q;

    assign a_wins = a_elig & (~b_elig | b_last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_last_q <= 1'b1;
        end else if (accept_a | accept_b) begin
            b_last_q <= accept_b;
        end
    end
`else
    assign a_wins = a_elig;
`endif

    always_comb begin
        accept_a = 1'b0;
        accept_b = 1'b0;
        unique case (state_q)
            StIdle: begin
                accept_a = a_wins;
                accept_b = ~a_wins & b_elig;
            end
            StLockA: accept_a = a_elig;
            StLockB: accept_b = b_elig;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            if (accept_a) begin
                state_q <= StServeA;
                we_q    <= a_we;
                addr_q  <= a_addr;
                wdata_q <= a_wdata;
            end else if (accept_b) begin
                state_q <= StServeB;
                we_q    <= b_we;
                addr_q  <= b_addr;
                wdata_q <= b_wdata;
            end else begin
                unique case (state_q)
                    StServeA: begin
                        a_ack_q <= 1'b1;
                        if (!we_q) begin
                            a_rdata_q <= ram_rdata;
                        end
                        state_q <= a_lock ? StLockA : StIdle;
                    end
                    StServeB: begin
                        b_ack_q <= 1'b1;
                        if (!we_q) begin
                            b_rdata_q <= ram_rdata;
                        end
                        state_q <= b_lock ? StLockB : StIdle;
                    end
                    StLockA: begin
                        if (!a_lock) begin
                            state_q <= StIdle;
                        end
                    end
                    StLockB: begin
                        if (!b_lock) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Write strobe is decoded from state so a reset during SERVE kills it immediately.
    assign ram_we    = we_q & ((state_q == StServeA) | (state_q == StServeB));
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

    always_comb begin
        owner = 2'b00;
        unique case (state_q)
            StServeA, StLockA: owner = 2'b01;
            StServeB, StLockB: owner = 2'b10;
            default:           owner = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level reference model, per-cycle compare, directed pins
// and randomized traffic. Honours RAM_ARB_RR_EN in the model's tie-break.
module tb_ram_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_ack, b_ack, ram_we;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [1:0]    owner;

    logic [DW-1:0] ram   [32];
    logic [DW-1:0] m_mem [32];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .owner(owner)
    );

    // Bench-side RAM: combinational read, write on the rising edge.
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: who is in service (0 none, 1 A, 2 B), who holds a lock, the latched
    // transaction, ack/rdata per requester and the last-served requester.
    int            m_serve, m_lock;
    bit            m_we, m_blast;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_ack [2];
    logic [DW-1:0] m_rd  [2];

    always @(posedge clk or negedge rst) begin : model
        int k, win;
        bit e0, e1;
        if (!rst) begin
            m_serve <= 0; m_lock <= 0; m_we <= 1'b0; m_blast <= 1'b1;
            m_addr <= '0; m_wdata <= '0;
            m_ack[0] <= 1'b0; m_ack[1] <= 1'b0; m_rd[0] <= '0; m_rd[1] <= '0;
        end else begin
            m_ack[0] <= 1'b0;
            m_ack[1] <= 1'b0;
            if (m_serve != 0) begin
                k = m_serve - 1;
                m_ack[k] <= 1'b1;
                if (m_we) m_mem[m_addr] <= m_wdata;
                else m_rd[k] <= m_mem[m_addr];
                m_lock  <= (((k == 0) ? a_lock : b_lock) != 1'b0) ? m_serve : 0;
                m_serve <= 0;
            end else begin
                e0  = a_req && !m_ack[0];
                e1  = b_req && !m_ack[1];
                win = 0;
                if (m_lock == 1) begin
                    if (e0) win = 1;
                    else if (!a_lock) m_lock <= 0;
                end else if (m_lock == 2) begin
                    if (e1) win = 2;
                    else if (!b_lock) m_lock <= 0;
                end else if (e0 && e1) begin
                    win = (RR && !m_blast) ? 2 : 1;
                end else if (e0) begin
                    win = 1;
                end else if (e1) begin
                    win = 2;
                end
                if (win != 0) begin
                    m_serve <= win;
                    m_lock  <= 0;
                    m_blast <= (win == 2);
                    m_we    <= (win == 1) ? a_we : b_we;
                    m_addr  <= (win == 1) ? a_addr : b_addr;
                    m_wdata <= (win == 1) ? a_wdata : b_wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("a_ack", 32'(a_ack), 32'(m_ack[0]));
        chk("b_ack", 32'(b_ack), 32'(m_ack[1]));
        chk("a_rdata", 32'(a_rdata), 32'(m_rd[0]));
        chk("b_rdata", 32'(b_rdata), 32'(m_rd[1]));
        chk("ram_we", 32'(ram_we), 32'((m_serve != 0) && m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        chk("owner", 32'(owner), 32'((m_serve != 0) ? m_serve : m_lock));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    initial begin
        int n, nb, wt;
        bit got;
        int ack_cyc [4];
        int who [4];
        for (int i = 0; i < 32; i++) begin
            ram[i]   <= 8'(i * 17);
            m_mem[i] <= 8'(i * 17);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset values.
        @(negedge clk);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);

        // Basic path: A writes 0xA5 to 5, B reads it back.
        @(posedge clk); #1 a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 8'hA5;
        @(posedge clk); #1 a_req = 0;
        @(negedge clk);
        chk("wr_we_serve", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'd5);
        @(negedge clk);
        chk("wr_we_after", 32'(ram_we), 32'd0);
        chk("wr_ack", 32'(a_ack), 32'd1);
        @(posedge clk); #1 b_req = 1; b_we = 0; b_addr = 5'd5;
        @(posedge clk); #1 b_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rd_b_ack", 32'(b_ack), 32'd1);
        chk("rd_b_rdata", 32'(b_rdata), 32'hA5);

        // Reset in the middle of a write to address 5.
        @(posedge clk); #1 a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 8'h3C;
        @(posedge clk); #1 a_req = 0;
        @(negedge clk); #2 rst = 1'b0;
        #1;
        chk("rstw_ram_we", 32'(ram_we), 32'd0);
        chk("rstw_owner", 32'(owner), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rstw_no_ack", 32'(a_ack), 32'd0);
        chk("rstw_ram5", 32'(ram[5]), 32'hA5);

        // Locked read burst of A over addresses 0..3 while B waits.
        @(posedge clk); #1 a_req = 1; a_we = 0; a_lock = 1; a_addr = 5'd0;
        @(posedge clk); #1 b_req = 1; b_we = 0; b_addr = 5'd2;
        n = 0; nb = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (b_ack) nb++;
            if (a_ack) begin
                ack_cyc[n] = cyc;
                chk("lock_rdata", 32'(a_rdata), 32'(n * 17));
                n++;
                if (n == 4) begin
                    a_lock = 0; a_req = 0;
                end else begin
                    a_addr = 5'(n);
                end
            end
        end
        chk("lock_acks", 32'(n), 32'd4);
        for (int i = 1; i < 4; i++) if (i < n) chk("lock_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        chk("lock_no_b_ack", 32'(nb), 32'd0);
        got = 0; wt = 0;
        while (!got && wt < 3) begin
            @(negedge clk);
            wt++;
            got = b_ack;
        end
        chk("lock_release_b_ack", 32'(got), 32'd1);
        chk("lock_release_b_rdata", 32'(b_rdata), 32'h22);
        b_req = 0;

        // Both requesters hold reads: the masked ack cycle lets the other one in.
        pulse_reset();
        @(posedge clk); #1 a_req = 1; a_we = 0; a_addr = 5'd1; b_req = 1; b_we = 0; b_addr = 5'd2;
        n = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (a_ack && n < 4) begin
                who[n] = 1; n++;
                chk("tie_a_rdata", 32'(a_rdata), 32'h11);
            end
            if (b_ack && n < 4) begin
                who[n] = 2; n++;
                chk("tie_b_rdata", 32'(b_rdata), 32'h22);
            end
        end
        a_req = 0; b_req = 0;
        chk("tie_acks", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) if (i < n) chk("tie_order", 32'(who[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // A alone holds req through its acks: one service every 3 cycles.
        repeat (3) @(posedge clk);
        #1 a_req = 1; a_we = 0; a_addr = 5'd3;
        n = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (a_ack) begin
                ack_cyc[n] = cyc;
                chk("mask_rdata", 32'(a_rdata), 32'h33);
                n++;
            end
        end
        a_req = 0;
        chk("mask_acks", 32'(n), 32'd4);
        for (int i = 1; i < 4; i++) if (i < n) chk("mask_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);

        // Randomized traffic with occasional resets, checked by the per-cycle compare.
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end
            a_req   = ($urandom_range(0, 3) != 0);
            a_we    = $urandom_range(0, 1) != 0;
            a_addr  = 5'($urandom_range(0, 31));
            a_wdata = 8'($urandom_range(0, 255));
            a_lock  = ($urandom_range(0, 3) == 0);
            b_req   = ($urandom_range(0, 2) != 0);
            b_we    = $urandom_range(0, 1) != 0;
            b_addr  = 5'($urandom_range(0, 31));
            b_wdata = 8'($urandom_range(0, 255));
            b_lock  = ($urandom_range(0, 3) == 0);
        end
        #1 a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) chk("mem_contents", 32'(ram[i]), 32'(m_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
